mmio_fifo_ctrl: RTL and testbench

// - Sequences the 64-bit AFU data FIFO from CCI-P MMIO traffic: write to DATA pushes, read of DATA pops.
// - Provides STATUS/CTRL CSRs; returns read data with fixed latency and the captured TID.
// - Sits between rx.c0 MMIO decode and the FIFO; the afu top ORs rsp_* into tx.c2 beside its own CSR mux.

---
 rtl/mmio_fifo_pkg.sv | 24 ++
 rtl/mmio_rsp_pipe.sv | 37 +++
 rtl/mmio_fifo_ctrl.sv | 140 ++++++++++++++
 tb/tb_mmio_fifo_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_fifo_pkg.sv
// rtl/mmio_fifo_pkg.sv - register offsets, STATUS/CTRL fields and response stage type
package mmio_fifo_pkg;

  localparam logic [15:0] OFS_DATA   = 16'd0;
  localparam logic [15:0] OFS_STATUS = 16'd2;
  localparam logic [15:0] OFS_CTRL   = 16'd4;

  localparam int ST_OVF   = 63;
  localparam int ST_UDF   = 62;
  localparam int ST_FULL  = 61;
  localparam int ST_EMPTY = 60;

  localparam logic [63:0] CTRL_FLUSH = 64'h1;
  localparam logic [63:0] CTRL_CLR   = 64'h2;

  typedef struct packed {
    logic        valid;
    logic [8:0]  tid;
    logic        is_data;
    logic        popped;
    logic [63:0] status;
  } t_rsp_stage;

endpackage

// File: rtl/mmio_rsp_pipe.sv
// rtl/mmio_rsp_pipe.sv - fixed-latency read response shift pipeline
module mmio_rsp_pipe
  import mmio_fifo_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  t_rsp_stage in_stage,
  output t_rsp_stage out_stage
);

  t_rsp_stage stage_q [STAGES];
  t_rsp_stage stage_d [STAGES];

  always_comb begin
    stage_d[0] = in_stage;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_stage = stage_q[STAGES-1];

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// rtl/mmio_fifo_ctrl.sv - MMIO sequencer for the AFU data FIFO with STATUS/CTRL CSRs
module mmio_fifo_ctrl
  import mmio_fifo_pkg::*;
#(
  parameter int          DEPTH  = 16,
  parameter int          RD_LAT = 1,
  parameter logic [15:0] BASE   = 16'h0030
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_wr,
  input  logic        mmio_rd,
  input  logic [15:0] mmio_addr,
  input  logic [8:0]  mmio_tid,
  input  logic [63:0] mmio_wdata,
  output logic        fifo_push,
  output logic [63:0] fifo_wdata,
  output logic        fifo_pop,
  input  logic [63:0] fifo_rdata,
  output logic        fifo_flush,
  output logic        rsp_valid,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data,
  output logic        hit
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          fifo_push_q, fifo_push_d, fifo_pop_q, fifo_pop_d, fifo_flush_q, fifo_flush_d;
  logic [63:0]   fifo_wdata_q, fifo_wdata_d;
  logic          sel_data, sel_status, sel_ctrl;
  logic          wr_data, rd_data, rd_status, wr_ctrl;
  logic          full, empty, push_ok, pop_ok;
  logic [63:0]   status_snap;
  t_rsp_stage    rsp_in, rsp_out;

  assign sel_data   = (mmio_addr == BASE + OFS_DATA);
  assign sel_status = (mmio_addr == BASE + OFS_STATUS);
  assign sel_ctrl   = (mmio_addr == BASE + OFS_CTRL);

  assign wr_data   = mmio_wr & sel_data;
  assign wr_ctrl   = mmio_wr & sel_ctrl;
  assign rd_data   = mmio_rd & sel_data;
  assign rd_status = mmio_rd & sel_status;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // Both decisions look at the pre-cycle count, so a same-cycle push cannot feed a pop.
  assign push_ok = wr_data & ~full;
  assign pop_ok  = rd_data & ~empty;

  assign hit = ~rst & (rd_data | rd_status);

  always_comb begin
    count_d      = count_q + CW'(push_ok) - CW'(pop_ok);
    ovf_d        = ovf_q;
    udf_d        = udf_q;
    fifo_push_d  = push_ok;
    fifo_pop_d   = pop_ok;
    fifo_flush_d = 1'b0;
    fifo_wdata_d = push_ok ? mmio_wdata : fifo_wdata_q;
    if (wr_ctrl) begin
      if ((mmio_wdata & CTRL_FLUSH) != '0) begin
        fifo_flush_d = 1'b1;
        count_d      = '0;
      end
      if ((mmio_wdata & CTRL_CLR) != '0) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
    end
    if (wr_data && full) ovf_d = 1'b1;
    if (rd_data && empty) udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      fifo_push_q  <= 1'b0;
      fifo_pop_q   <= 1'b0;
      fifo_flush_q <= 1'b0;
      fifo_wdata_q <= '0;
    end else begin
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      fifo_push_q  <= fifo_push_d;
      fifo_pop_q   <= fifo_pop_d;
      fifo_flush_q <= fifo_flush_d;
      fifo_wdata_q <= fifo_wdata_d;
    end
  end

  assign fifo_push  = fifo_push_q;
  assign fifo_pop   = fifo_pop_q;
  assign fifo_flush = fifo_flush_q;
  assign fifo_wdata = fifo_wdata_q;

  always_comb begin
    status_snap           = '0;
    status_snap[ST_OVF]   = ovf_q;
    status_snap[ST_UDF]   = udf_q;
    status_snap[ST_FULL]  = full;
    status_snap[ST_EMPTY] = empty;
    status_snap[15:0]     = 16'(count_q);
    rsp_in.valid   = rd_data | rd_status;
    rsp_in.tid     = mmio_tid;
    rsp_in.is_data = rd_data;
    rsp_in.popped  = pop_ok;
    rsp_in.status  = status_snap;
  end

  mmio_rsp_pipe #(.STAGES(RD_LAT + 1)) u_rsp_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_stage  (rsp_in),
    .out_stage (rsp_out)
  );

  // The last stage lines up with the FIFO read data of the pop issued for it.
  always_comb begin
    rsp_valid = rsp_out.valid;
    rsp_tid   = '0;
    rsp_data  = '0;
    if (rsp_out.valid) begin
      rsp_tid = rsp_out.tid;
      if (rsp_out.is_data) begin
        rsp_data = rsp_out.popped ? fifo_rdata : '0;
      end else begin
        rsp_data = rsp_out.status;
      end
    end
  end

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// tb/tb_mmio_fifo_ctrl.sv - randomized check of mmio_fifo_ctrl against a queue-based model
module tb_mmio_fifo_ctrl;

  localparam logic [15:0] A_DATA = 16'h0030;
  localparam logic [15:0] A_STAT = 16'h0032;
  localparam logic [15:0] A_CTRL = 16'h0034;
  localparam int          DEPTH  = 16;

  logic        clk, rst;
  logic        mmio_wr, mmio_rd;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wdata;
  logic        fifo_push, fifo_pop, fifo_flush;
  logic [63:0] fifo_wdata, fifo_rdata;
  logic        rsp_valid, hit;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;

  mmio_fifo_ctrl #(.DEPTH(DEPTH), .RD_LAT(1), .BASE(A_DATA)) dut (
    .clk        (clk),
    .rst        (rst),
    .mmio_wr    (mmio_wr),
    .mmio_rd    (mmio_rd),
    .mmio_addr  (mmio_addr),
    .mmio_tid   (mmio_tid),
    .mmio_wdata (mmio_wdata),
    .fifo_push  (fifo_push),
    .fifo_wdata (fifo_wdata),
    .fifo_pop   (fifo_pop),
    .fifo_rdata (fifo_rdata),
    .fifo_flush (fifo_flush),
    .rsp_valid  (rsp_valid),
    .rsp_tid    (rsp_tid),
    .rsp_data   (rsp_data),
    .hit        (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // FIFO stand-in driven only by the DUT strobes, head valid one cycle after a pop.
  logic [63:0] fq[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      fifo_rdata <= '0;
    end else begin
      if (fifo_pop && fq.size() > 0) begin
        fifo_rdata <= fq[0];
        fq.pop_front();
      end
      if (fifo_push) fq.push_back(fifo_wdata);
      if (fifo_flush) fq.delete();
    end
  end

  // Reference model: contents as a queue, sticky flags, expectations by cycle slot.
  logic [63:0] mq[$];
  logic        m_ovf, m_udf;
  logic        e_push[4], e_pop[4], e_flush[4], e_rv[4];
  logic [63:0] e_wdata[4], e_data[4];
  logic [8:0]  e_tid[4];
  int          cyc;

  task automatic clear_slot(input int s);
    e_push[s] = 0; e_pop[s] = 0; e_flush[s] = 0; e_rv[s] = 0;
    e_wdata[s] = '0; e_data[s] = '0; e_tid[s] = '0;
  endtask

  task automatic step(input logic wr, input logic rd, input logic [15:0] addr,
                      input logic [63:0] wd, input logic [8:0] tid);
    int s0, s1, s2, pre;
    logic [63:0] snap;
    logic exp_hit;
    @(negedge clk);
    s0 = cyc % 4; s1 = (cyc + 1) % 4; s2 = (cyc + 2) % 4;
    check_eq("fifo_push", 64'(fifo_push), 64'(e_push[s0]));
    if (e_push[s0]) check_eq("fifo_wdata", fifo_wdata, e_wdata[s0]);
    check_eq("fifo_pop", 64'(fifo_pop), 64'(e_pop[s0]));
    check_eq("fifo_flush", 64'(fifo_flush), 64'(e_flush[s0]));
    check_eq("rsp_valid", 64'(rsp_valid), 64'(e_rv[s0]));
    if (e_rv[s0]) begin
      check_eq("rsp_tid", 64'(rsp_tid), 64'(e_tid[s0]));
      check_eq("rsp_data", rsp_data, e_data[s0]);
    end
    clear_slot(s0);

    pre  = mq.size();
    snap = {m_ovf, m_udf, pre == DEPTH, pre == 0, 44'b0, 16'(pre)};
    exp_hit = rd && (addr == A_DATA || addr == A_STAT);
    if (rd && addr == A_DATA) begin
      e_rv[s2] = 1; e_tid[s2] = tid;
      if (pre > 0) begin
        e_pop[s1]  = 1;
        e_data[s2] = mq.pop_front();
      end else begin
        m_udf = 1;
        e_data[s2] = '0;
      end
    end
    if (rd && addr == A_STAT) begin
      e_rv[s2] = 1; e_tid[s2] = tid; e_data[s2] = snap;
    end
    if (wr && addr == A_DATA) begin
      if (pre < DEPTH) begin
        mq.push_back(wd);
        e_push[s1] = 1; e_wdata[s1] = wd;
      end else begin
        m_ovf = 1;
      end
    end
    if (wr && addr == A_CTRL) begin
      if (wd[0]) begin
        mq.delete();
        e_flush[s1] = 1;
      end
      if (wd[1]) begin
        m_ovf = 0; m_udf = 0;
      end
    end

    mmio_wr = wr; mmio_rd = rd; mmio_addr = addr; mmio_wdata = wd; mmio_tid = tid;
    #1;
    check_eq("hit", 64'(hit), 64'(exp_hit));
    cyc++;
  endtask

  task automatic mmio_write(input logic [15:0] addr, input logic [63:0] d);
    step(1'b1, 1'b0, addr, d, 9'd0);
  endtask

  task automatic mmio_read(input logic [15:0] addr, input logic [8:0] tid);
    step(1'b0, 1'b1, addr, 64'd0, tid);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0, 64'd0, 9'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    mmio_wr = 1'b1; mmio_rd = 1'b1; mmio_addr = A_STAT; mmio_wdata = '1; mmio_tid = 9'h1ff;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("rst_push", 64'(fifo_push), 64'd0);
      check_eq("rst_wdata", fifo_wdata, 64'd0);
      check_eq("rst_pop", 64'(fifo_pop), 64'd0);
      check_eq("rst_flush", 64'(fifo_flush), 64'd0);
      check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check_eq("rst_rsp_tid", 64'(rsp_tid), 64'd0);
      check_eq("rst_rsp_data", rsp_data, 64'd0);
      check_eq("rst_hit", 64'(hit), 64'd0);
      @(negedge clk);
    end
    mq.delete(); m_ovf = 0; m_udf = 0; cyc = 0;
    for (int s = 0; s < 4; s++) clear_slot(s);
    mmio_wr = 0; mmio_rd = 0; mmio_addr = '0; mmio_wdata = '0; mmio_tid = '0;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r;
    logic [63:0] d;
    logic [8:0]  t;
    logic        heavy;
    rst = 1'b1;
    mmio_wr = 0; mmio_rd = 0; mmio_addr = '0; mmio_wdata = '0; mmio_tid = '0;
    apply_reset();

    mmio_read(A_STAT, 9'd5);
    idle(3);

    mmio_write(A_DATA, 64'hA);
    mmio_write(A_DATA, 64'hB);
    mmio_read(A_DATA, 9'd1);
    mmio_read(A_DATA, 9'd2);
    mmio_read(A_STAT, 9'd3);
    idle(3);

    for (int i = 0; i < 17; i++) mmio_write(A_DATA, 64'h100 + 64'(i));
    mmio_read(A_STAT, 9'd7);
    mmio_write(A_CTRL, 64'h2);
    mmio_read(A_STAT, 9'd8);
    idle(2);

    mmio_write(A_CTRL, 64'h1);
    mmio_read(A_DATA, 9'd9);
    mmio_read(A_STAT, 9'd10);
    mmio_write(A_CTRL, 64'h3);
    step(1'b1, 1'b1, A_DATA, 64'hC0DE, 9'd11);
    mmio_read(A_STAT, 9'd12);
    idle(2);

    mmio_write(A_DATA, 64'h55);
    mmio_read(A_DATA, 9'd13);
    mmio_write(A_CTRL, 64'h1);
    mmio_read(A_STAT, 9'd14);
    mmio_read(A_CTRL, 9'd15);
    mmio_write(A_STAT, 64'hFFFF);
    step(1'b1, 1'b1, 16'h0040, 64'h77, 9'd16);
    mmio_read(A_STAT, 9'd17);
    idle(3);

    mmio_write(A_DATA, 64'h99);
    mmio_read(A_DATA, 9'd20);
    mmio_read(A_STAT, 9'd21);
    apply_reset();
    idle(4);
    mmio_read(A_STAT, 9'd22);
    idle(3);

    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 15);
      d = {$urandom, $urandom};
      t = 9'($urandom);
      heavy = (((i / 150) % 2) == 1);
      if (heavy && r >= 5 && r <= 8) r = 0;
      case (r)
        0, 1, 2, 3, 4: step(1'b1, 1'b0, A_DATA, d, t);
        5, 6, 7, 8:    step(1'b0, 1'b1, A_DATA, d, t);
        9, 10:         step(1'b0, 1'b1, A_STAT, d, t);
        11: begin
          d[0] = ($urandom_range(0, 3) == 0);
          step(1'b1, 1'b0, A_CTRL, d, t);
        end
        12:      step(1'b1, 1'b1, A_DATA, d, t);
        13:      step(1'b0, 1'b1, A_CTRL, d, t);
        14:      step(1'b1, 1'b0, A_STAT, d, t);
        default: step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      16'($urandom_range(16'h2c, 16'h38)), d, t);
      endcase
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
